// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits LSB first, odd parity, stop, ack check.
// Data-line changes land one cycle after the filtered clock fall; wr_ps2 is honoured only while idle.
module ps2_tx #(
  parameter int RTS_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  tri         ps2d,
  inout  tri         ps2c,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;

  state_t        state, state_next;
  logic [7:0]    filt_reg;
  logic          f_reg, f_next, fall;
  logic [1:0]    d_sync;
  logic [8:0]    b_reg, b_next;
  logic [3:0]    n_reg, n_next;
  logic [CW-1:0] c_reg, c_next;
  logic          done_next, ack_next;
  logic          c_low, d_low;

  // Filtered clock only flips on eight identical samples, otherwise it holds.
  always_comb begin
    f_next = f_reg;
    if (filt_reg == 8'hFF)
      f_next = 1'b1;
    else if (filt_reg == 8'h00)
      f_next = 1'b0;
  end

  assign fall = f_reg & ~f_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      filt_reg     <= 8'hFF;
      f_reg        <= 1'b1;
      d_sync       <= 2'b11;
      b_reg        <= '0;
      n_reg        <= '0;
      c_reg        <= '0;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      state        <= state_next;
      filt_reg     <= {ps2c, filt_reg[7:1]};
      f_reg        <= f_next;
      d_sync       <= {d_sync[0], ps2d};
      b_reg        <= b_next;
      n_reg        <= n_next;
      c_reg        <= c_next;
      tx_done_tick <= done_next;
      ack_err      <= ack_next;
    end
  end

  always_comb begin
    state_next = state;
    b_next     = b_reg;
    n_next     = n_reg;
    c_next     = c_reg;
    done_next  = 1'b0;
    ack_next   = ack_err;
    case (state)
      IDLE: begin
        if (wr_ps2) begin
          b_next     = {~^din, din};
          c_next     = CW'(RTS_CYCLES - 1);
          state_next = RTS;
        end
      end
      RTS: begin
        if (c_reg == '0)
          state_next = START;
        else
          c_next = c_reg - 1'b1;
      end
      START: begin
        if (fall) begin
          n_next     = 4'd8;
          state_next = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          b_next = {1'b0, b_reg[8:1]};
          if (n_reg == 4'd0)
            state_next = STOP;
          else
            n_next = n_reg - 1'b1;
        end
      end
      STOP: begin
        if (fall)
          state_next = ACK;
      end
      ACK: begin
        if (fall) begin
          ack_next   = d_sync[1];
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    c_low   = (state == RTS);
    d_low   = (state == START) || ((state == DATA) && !b_reg[0]);
    tx_idle = (state == IDLE);
  end

  // Open-drain: only ever pull low or release.
  assign ps2c = c_low ? 1'b0 : 1'bz;
  assign ps2d = d_low ? 1'b0 : 1'bz;

endmodule
